jtag_core_shift_engine: RTL and testbench

JTAG_CORE_SHIFT_ENGINE -- requirements
Module: jtag_core_shift_engine

---
 rtl/jtag_core_shift_engine.sv | 197 +++++++++++++++++++
 tb/tb_jtag_core_shift_engine.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_core_shift_engine.sv
// jtag_core_shift_engine: runs one IR scan plus an optional DR scan on a
// core-side JTAG atom per request, generating TCK from clk, capturing TDO
// during Shift-DR, and falling back to Test-Logic-Reset on abort.
module jtag_core_shift_engine #(
    parameter int unsigned IR_WIDTH = 10,
    parameter int unsigned DR_WIDTH = 32,
    parameter int unsigned TCK_DIV  = 2
) (
    input  logic                          clk,
    input  logic                          i_resetn,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic [IR_WIDTH-1:0]           i_ir_value,
    input  logic [DR_WIDTH-1:0]           i_dr_value,
    input  logic [$clog2(DR_WIDTH+1)-1:0] i_dr_len,
    input  logic                          i_tdo_core,
    output logic                          o_jtag_core_en,
    output logic                          o_tck_core,
    output logic                          o_tms_core,
    output logic                          o_tdi_core,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_error,
    output logic [DR_WIDTH-1:0]           o_dr_capture
);

    localparam int unsigned LEN_W    = $clog2(DR_WIDTH + 1);
    localparam int unsigned MAX_A    = (DR_WIDTH > IR_WIDTH) ? DR_WIDTH : IR_WIDTH;
    localparam int unsigned MAX_BITS = (MAX_A > 6) ? MAX_A : 6;
    localparam int unsigned IDX_W    = $clog2(MAX_BITS + 1);
    localparam int unsigned BIT_CYC  = 2 * TCK_DIV;
    localparam int unsigned CNT_W    = $clog2(BIT_CYC);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RESET,
        S_IR_HDR,
        S_IR_SHIFT,
        S_IR_TAIL,
        S_DR_HDR,
        S_DR_SHIFT,
        S_DR_TAIL,
        S_ABORT,
        S_FINISH
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IR_WIDTH-1:0]  ir_q;
    logic [DR_WIDTH-1:0]  dr_q;
    logic [LEN_W-1:0]     len_q;
    logic                 abort_pend_q;

    logic                 last_bit;
    logic                 abort_go;
    state_t               nxt_state;
    logic [IDX_W-1:0]     nxt_idx;
    logic                 nxt_tms;
    logic                 nxt_tdi;
    logic [IR_WIDTH-1:0]  ir_sh;
    logic [DR_WIDTH-1:0]  dr_sh;

    // Index of the final bit of each TMS segment.
    function automatic logic [IDX_W-1:0] seg_last(input state_t s, input logic [LEN_W-1:0] len);
        case (s)
            S_RESET:    seg_last = IDX_W'(5);
            S_IR_HDR:   seg_last = IDX_W'(3);
            S_IR_SHIFT: seg_last = IDX_W'(IR_WIDTH - 1);
            S_IR_TAIL:  seg_last = IDX_W'(1);
            S_DR_HDR:   seg_last = IDX_W'(2);
            S_DR_SHIFT: seg_last = IDX_W'(len) - IDX_W'(1);
            S_DR_TAIL:  seg_last = IDX_W'(1);
            S_ABORT:    seg_last = IDX_W'(4);
            default:    seg_last = '0;
        endcase
    endfunction

    // Segment that follows a completed segment.
    function automatic state_t seg_next(input state_t s, input logic [LEN_W-1:0] len);
        case (s)
            S_RESET:    seg_next = S_IR_HDR;
            S_IR_HDR:   seg_next = S_IR_SHIFT;
            S_IR_SHIFT: seg_next = S_IR_TAIL;
            S_IR_TAIL:  seg_next = (len == '0) ? S_FINISH : S_DR_HDR;
            S_DR_HDR:   seg_next = S_DR_SHIFT;
            S_DR_SHIFT: seg_next = S_DR_TAIL;
            default:    seg_next = S_FINISH;
        endcase
    endfunction

    // Decode the segment, index and TMS/TDI levels of the upcoming bit.
    always_comb begin
        last_bit  = (idx_q == seg_last(state_q, len_q));
        abort_go  = (abort_pend_q || i_abort) && (state_q != S_ABORT);
        nxt_state = state_q;
        nxt_idx   = idx_q + IDX_W'(1);
        nxt_tms   = 1'b1;
        nxt_tdi   = 1'b0;
        if (abort_go) begin
            nxt_state = S_ABORT;
            nxt_idx   = '0;
        end else if (last_bit) begin
            nxt_state = seg_next(state_q, len_q);
            nxt_idx   = '0;
        end
        ir_sh = ir_q >> nxt_idx;
        dr_sh = dr_q >> nxt_idx;
        case (nxt_state)
            S_RESET:    nxt_tms = (nxt_idx != IDX_W'(5));
            S_IR_HDR:   nxt_tms = (nxt_idx < IDX_W'(2));
            S_IR_SHIFT: begin
                nxt_tms = (nxt_idx == IDX_W'(IR_WIDTH - 1));
                nxt_tdi = ir_sh[0];
            end
            S_IR_TAIL,
            S_DR_HDR,
            S_DR_TAIL:  nxt_tms = (nxt_idx == '0);
            S_DR_SHIFT: begin
                nxt_tms = (nxt_idx == (IDX_W'(len_q) - IDX_W'(1)));
                nxt_tdi = dr_sh[0];
            end
            default:    nxt_tms = 1'b1;
        endcase
    end

    // Transaction sequencer: accept, TCK bit timing, segment stepping, capture, finish.
    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            ir_q           <= '0;
            dr_q           <= '0;
            len_q          <= '0;
            abort_pend_q   <= 1'b0;
            o_jtag_core_en <= 1'b0;
            o_tck_core     <= 1'b0;
            o_tms_core     <= 1'b1;
            o_tdi_core     <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
            o_dr_capture   <= '0;
        end else begin
            o_done <= 1'b0;
            if (!o_busy) begin
                if (i_start) begin
                    state_q        <= S_RESET;
                    idx_q          <= '0;
                    cnt_q          <= '0;
                    ir_q           <= i_ir_value;
                    dr_q           <= i_dr_value;
                    len_q          <= (i_dr_len > LEN_W'(DR_WIDTH)) ? LEN_W'(DR_WIDTH) : i_dr_len;
                    abort_pend_q   <= 1'b0;
                    o_jtag_core_en <= 1'b1;
                    o_busy         <= 1'b1;
                    o_tck_core     <= 1'b0;
                    o_tms_core     <= 1'b1;
                    o_tdi_core     <= 1'b0;
                    o_error        <= 1'b0;
                    o_dr_capture   <= '0;
                end
            end else begin
                if (i_abort && (state_q != S_ABORT)) begin
                    abort_pend_q <= 1'b1;
                end
                if ((state_q == S_DR_SHIFT) && (cnt_q == CNT_W'(TCK_DIV))) begin
                    o_dr_capture <= o_dr_capture | (DR_WIDTH'(i_tdo_core) << idx_q);
                end
                if (cnt_q == CNT_W'(BIT_CYC - 1)) begin
                    cnt_q        <= '0;
                    o_tck_core   <= 1'b0;
                    abort_pend_q <= 1'b0;
                    if (nxt_state == S_FINISH) begin
                        state_q        <= S_IDLE;
                        idx_q          <= '0;
                        o_busy         <= 1'b0;
                        o_jtag_core_en <= 1'b0;
                        o_done         <= 1'b1;
                        o_error        <= (state_q == S_ABORT);
                        o_tdi_core     <= 1'b0;
                    end else begin
                        state_q    <= nxt_state;
                        idx_q      <= nxt_idx;
                        o_tms_core <= nxt_tms;
                        o_tdi_core <= nxt_tdi;
                    end
                end else begin
                    cnt_q      <= cnt_q + CNT_W'(1);
                    o_tck_core <= ((cnt_q + CNT_W'(1)) >= CNT_W'(TCK_DIV));
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_core_shift_engine.sv
// Bench for jtag_core_shift_engine: flat bit-list scan model checked every
// cycle, a TAP state machine observing the pins, and directed transactions.
`timescale 1ns/1ps
module tb_jtag_core_shift_engine;

    localparam int D   = 2;
    localparam int BC  = 2 * D;
    localparam int IRW = 10;
    localparam int DRW = 32;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        abrt;
    logic [9:0]  ir;
    logic [31:0] dr;
    logic [5:0]  len;
    logic        tdo = 1'b0;

    logic        o_jtag_core_en, o_tck_core, o_tms_core, o_tdi_core;
    logic        o_busy, o_done, o_error;
    logic [31:0] o_dr_capture;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtag_core_shift_engine #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .TCK_DIV(D)) dut (
        .clk           (clk),
        .i_resetn      (rstn),
        .i_start       (start),
        .i_abort       (abrt),
        .i_ir_value    (ir),
        .i_dr_value    (dr),
        .i_dr_len      (len),
        .i_tdo_core    (tdo),
        .o_jtag_core_en(o_jtag_core_en),
        .o_tck_core    (o_tck_core),
        .o_tms_core    (o_tms_core),
        .o_tdi_core    (o_tdi_core),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_dr_capture  (o_dr_capture)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // ---------------- TAP controller observing the pins ----------------
    typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUSEDR, EX2DR, UPDR,
                              SELIR, CAPIR, SHIR, EX1IR, PAUSEIR, EX2IR, UPIR} tap_t;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        case (s)
            TLR:     return tms ? TLR   : RTI;
            RTI:     return tms ? SELDR : RTI;
            SELDR:   return tms ? SELIR : CAPDR;
            CAPDR:   return tms ? EX1DR : SHDR;
            SHDR:    return tms ? EX1DR : SHDR;
            EX1DR:   return tms ? UPDR  : PAUSEDR;
            PAUSEDR: return tms ? EX2DR : PAUSEDR;
            EX2DR:   return tms ? UPDR  : SHDR;
            UPDR:    return tms ? SELDR : RTI;
            SELIR:   return tms ? TLR   : CAPIR;
            CAPIR:   return tms ? EX1IR : SHIR;
            SHIR:    return tms ? EX1IR : SHIR;
            EX1IR:   return tms ? UPIR  : PAUSEIR;
            PAUSEIR: return tms ? EX2IR : PAUSEIR;
            EX2IR:   return tms ? UPIR  : SHIR;
            default: return tms ? SELDR : RTI;
        endcase
    endfunction

    tap_t        tap = TLR;
    logic        prev_tck = 1'b0;
    logic [9:0]  ir_seen = '0;
    logic [31:0] dr_seen = '0;
    logic [31:0] tdo_pat = '0;
    int          dr_cnt = 0;
    int          busy_cyc = 0;
    int          done_cnt = 0;

    // TAP follows TMS on rising TCK; TDO presents the next pattern bit on falling TCK.
    always @(negedge clk) begin
        if (o_busy) busy_cyc++;
        if (o_done) done_cnt++;
        if (o_tck_core && !prev_tck) begin
            if (tap == SHIR) ir_seen = {o_tdi_core, ir_seen[9:1]};
            if (tap == SHDR) begin
                dr_seen = {o_tdi_core, dr_seen[31:1]};
                dr_cnt++;
            end
            if (tap == CAPDR) dr_cnt = 0;
            tap = tap_next(tap, o_tms_core);
        end
        if (!o_tck_core && prev_tck) begin
            if (tap == SHDR && dr_cnt < 32) tdo = tdo_pat[dr_cnt];
            else tdo = 1'b0;
        end
        prev_tck = o_tck_core;
    end

    // ---------------- bit-list scan model, checked every cycle ----------------
    bit          q_tms[$];
    bit          q_tdi[$];
    int          q_drk[$];
    bit          m_active = 1'b0;
    int          m_n = 0;
    int          m_total = 0;
    int          m_abort_from = -1;
    bit          m_err = 1'b0;
    logic [31:0] m_cap = '0;
    logic [31:0] m_pat = '0;

    function automatic void push_bit(input bit t, input bit d, input int k);
        q_tms.push_back(t);
        q_tdi.push_back(d);
        q_drk.push_back(k);
    endfunction

    always @(negedge clk) begin
        logic [6:0] act, exp, mask;
        bit         busy_e, done_e, cap_chk;
        int         b, ph, l;
        act = {o_tck_core, o_tms_core, o_tdi_core, o_jtag_core_en, o_busy, o_done, o_error};
        b = 0;
        busy_e = 1'b0;
        if (!rstn) begin
            m_active = 1'b0;
            m_err    = 1'b0;
            m_cap    = '0;
            exp      = 7'b0100000;
            mask     = 7'b1111111;
            cap_chk  = 1'b1;
        end else begin
            busy_e = m_active && (m_n < m_total * BC);
            done_e = m_active && (m_n == m_total * BC);
            if (done_e) begin
                m_err = (m_abort_from >= 0);
                m_cap = '0;
                for (int i = 0; i < q_drk.size(); i++)
                    if (q_drk[i] >= 0) m_cap[q_drk[i]] = m_pat[q_drk[i]];
            end
            if (busy_e) begin
                b  = m_n / BC;
                ph = m_n % BC;
                exp     = {(ph >= D), q_tms[b], q_tdi[b], 1'b1, 1'b1, 1'b0, 1'b0};
                mask    = 7'b1111110;
                cap_chk = 1'b0;
            end else begin
                exp     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, done_e, m_err};
                mask    = 7'b1011111;
                cap_chk = 1'b1;
            end
        end
        checks++;
        if ((((act ^ exp) & mask) !== 7'b0) || (cap_chk && (o_dr_capture !== m_cap))) begin
            errors++;
            $display("FAIL cycle t=%0t outs act=%b exp=%b mask=%b cap act=%h exp=%h",
                     $time, act, exp, mask, o_dr_capture, cap_chk ? m_cap : o_dr_capture);
        end
        if (rstn) begin
            if (busy_e && abrt && m_abort_from < 0) begin
                m_abort_from = b + 1;
                while (q_tms.size() > b + 1) begin
                    void'(q_tms.pop_back());
                    void'(q_tdi.pop_back());
                    void'(q_drk.pop_back());
                end
                repeat (5) push_bit(1'b1, 1'b0, -1);
                m_total = b + 6;
            end
            if (!busy_e && start) begin
                q_tms.delete(); q_tdi.delete(); q_drk.delete();
                repeat (5) push_bit(1'b1, 1'b0, -1);
                push_bit(1'b0, 1'b0, -1);
                push_bit(1'b1, 1'b0, -1); push_bit(1'b1, 1'b0, -1);
                push_bit(1'b0, 1'b0, -1); push_bit(1'b0, 1'b0, -1);
                for (int k = 0; k < IRW; k++) push_bit(k == IRW - 1, ir[k], -1);
                push_bit(1'b1, 1'b0, -1); push_bit(1'b0, 1'b0, -1);
                l = (int'(len) > DRW) ? DRW : int'(len);
                if (l != 0) begin
                    push_bit(1'b1, 1'b0, -1); push_bit(1'b0, 1'b0, -1); push_bit(1'b0, 1'b0, -1);
                    for (int k = 0; k < l; k++) push_bit(k == l - 1, dr[k], k);
                    push_bit(1'b1, 1'b0, -1); push_bit(1'b0, 1'b0, -1);
                end
                m_total      = q_tms.size();
                m_active     = 1'b1;
                m_n          = 0;
                m_abort_from = -1;
                m_pat        = tdo_pat;
            end else if (m_active) begin
                m_n++;
                if (m_n > m_total * BC) m_active = 1'b0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic start_txn(input logic [9:0] i, input logic [31:0] d, input logic [5:0] n,
                             input logic [31:0] p, input logic with_abort);
        ir = i; dr = d; len = n; tdo_pat = p; abrt = with_abort; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abrt = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (k < 600 && o_done !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(k < 600), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int b0, d0;
        rstn = 1'b0; start = 1'b0; abrt = 1'b0; ir = '0; dr = '0; len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pins", 64'({o_tck_core, o_tms_core, o_tdi_core, o_jtag_core_en, o_busy, o_done, o_error}), 64'b0100000);
        chk("reset_cap", 64'(o_dr_capture), 64'h0);
        rstn = 1'b1;
        idle(2);

        // abort while idle is ignored
        abrt = 1'b1; idle(1); abrt = 1'b0; idle(2);
        chk("idle_abort_busy", 64'(o_busy), 64'd0);
        chk("idle_abort_err", 64'(o_error), 64'd0);

        // IR only, start with a simultaneous abort
        b0 = busy_cyc; d0 = done_cnt;
        start_txn(10'h3F2, 32'h0, 6'd0, 32'h0, 1'b1);
        wait_done("t_ir_only_done");
        chk("t_ir_only_busy", 64'(busy_cyc - b0), 64'd88);
        chk("t_ir_only_irbits", 64'(ir_seen), 64'h3F2);
        chk("t_ir_only_err", 64'(o_error), 64'd0);
        chk("t_ir_only_tap", 64'(tap), 64'(RTI));
        idle(5);
        chk("t_ir_only_ndone", 64'(done_cnt - d0), 64'd1);

        // full 32-bit DR
        b0 = busy_cyc;
        start_txn(10'h00E, 32'hA5A55A5A, 6'd32, 32'hDEADBEEF, 1'b0);
        wait_done("t_dr32_done");
        chk("t_dr32_busy", 64'(busy_cyc - b0), 64'd236);
        chk("t_dr32_cap", 64'(o_dr_capture), 64'hDEADBEEF);
        chk("t_dr32_drbits", 64'(dr_seen), 64'hA5A55A5A);
        chk("t_dr32_irbits", 64'(ir_seen), 64'h00E);
        chk("t_dr32_tap", 64'(tap), 64'(RTI));

        // short DR, TDO held high
        b0 = busy_cyc;
        start_txn(10'h155, 32'h3C, 6'd8, 32'hFFFFFFFF, 1'b0);
        wait_done("t_dr8_done");
        chk("t_dr8_busy", 64'(busy_cyc - b0), 64'd140);
        chk("t_dr8_cap", 64'(o_dr_capture), 64'h000000FF);

        // length clamped
        b0 = busy_cyc;
        start_txn(10'h0F0, 32'h0F0F0F0F, 6'd40, 32'h12345678, 1'b0);
        wait_done("t_clamp_done");
        chk("t_clamp_busy", 64'(busy_cyc - b0), 64'd236);
        chk("t_clamp_cap", 64'(o_dr_capture), 64'h12345678);
        chk("t_clamp_drbits", 64'(dr_seen), 64'h0F0F0F0F);

        // abort in DR shift bit 5, then a second abort during the reset bits
        b0 = busy_cyc;
        start_txn(10'h155, 32'h0, 6'd16, 32'hFFFFFFFF, 1'b0);
        repeat (121) @(posedge clk);
        #1;
        abrt = 1'b1; idle(1); abrt = 1'b0;
        idle(8);
        abrt = 1'b1; idle(1); abrt = 1'b0;
        wait_done("t_abort_done");
        chk("t_abort_busy", 64'(busy_cyc - b0), 64'd144);
        chk("t_abort_err", 64'(o_error), 64'd1);
        chk("t_abort_cap", 64'(o_dr_capture), 64'h0000003F);
        chk("t_abort_tap", 64'(tap), 64'(TLR));

        // reset during IR shift bit 3
        d0 = done_cnt;
        start_txn(10'h2CB, 32'h1F, 6'd5, 32'h1F, 1'b0);
        repeat (53) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("t_rst_pins", 64'({o_tck_core, o_tms_core, o_tdi_core, o_jtag_core_en, o_busy, o_done, o_error}), 64'b0100000);
        chk("t_rst_cap", 64'(o_dr_capture), 64'h0);
        @(posedge clk); #1;
        idle(2);
        chk("t_rst_nodone", 64'(done_cnt - d0), 64'd0);
        rstn = 1'b1;
        b0 = busy_cyc; d0 = done_cnt;
        start_txn(10'h155, 32'h5, 6'd4, 32'hA, 1'b0);
        wait_done("t_rst_new_done");
        chk("t_rst_new_busy", 64'(busy_cyc - b0), 64'd124);
        chk("t_rst_new_cap", 64'(o_dr_capture), 64'h0000000A);
        chk("t_rst_new_ndone", 64'(done_cnt - d0), 64'd1);
        chk("t_rst_new_tap", 64'(tap), 64'(RTI));

        // start while busy is dropped
        b0 = busy_cyc; d0 = done_cnt;
        start_txn(10'h2AA, 32'h7, 6'd3, 32'h6, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        ir = 10'h3FF; len = 6'd0; start = 1'b1; idle(1); start = 1'b0;
        wait_done("t_mid_done");
        idle(10);
        chk("t_mid_busy", 64'(busy_cyc - b0), 64'd120);
        chk("t_mid_ndone", 64'(done_cnt - d0), 64'd1);
        chk("t_mid_cap", 64'(o_dr_capture), 64'h00000006);
        chk("t_mid_irbits", 64'(ir_seen), 64'h2AA);
        chk("t_mid_tap", 64'(tap), 64'(RTI));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
